// File: rtl/sik_pkg.sv
// sik_pkg: shared widths, opcodes and thread-id type for the two-thread stack processor.
package sik_pkg;
  localparam int WORD_W = 16;
  localparam int PRE_W = 4;
  localparam int IMM_W = 12;
  localparam logic [3:0] OP_PRE = 4'h0;
  localparam logic [3:0] OP_JMP = 4'h1;
  localparam logic [3:0] OP_CALL = 4'h2;
  localparam logic [3:0] OP_ALU = 4'h3;
  localparam logic [3:0] OP_LIT = 4'h4;
  localparam logic [3:0] OP_SYS = 4'hF;
  localparam logic [WORD_W-1:0] NOOP = 16'h3000;
  typedef logic tid_t;
endpackage

// File: rtl/thread_sched_rr_pick2.sv
// rr_pick2: combinational two-way round-robin picker favouring the thread not granted last.
module rr_pick2
  import sik_pkg::*;
(
  input  logic [1:0] req,
  input  tid_t       last,
  output logic       gnt_valid,
  output tid_t       gnt_tid
);
  assign gnt_valid = |req;
  assign gnt_tid = &req ? ~last : req[1];
endmodule

// File: rtl/thread_sched.sv
// thread_sched: per-thread PC, prefix and halt state with round-robin fetch slot issue.
module thread_sched
  import sik_pkg::*;
#(
  parameter int AW = 16,
  parameter logic [AW-1:0] PC_T0 = 16'h0000,
  parameter logic [AW-1:0] PC_T1 = 16'h0001,
  parameter int PC_STEP = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic             redir_valid,
  input  tid_t             redir_tid,
  input  logic [IMM_W-1:0] redir_imm,
  input  logic             pre_load,
  input  tid_t             pre_tid,
  input  logic [PRE_W-1:0] pre_val,
  input  logic             halt_req,
  input  tid_t             halt_tid,
  output logic             fetch_valid,
  output logic [AW-1:0]    fetch_addr,
  output tid_t             fetch_tid,
  output logic [1:0]       halted,
  output logic             halt
);
  logic [AW-1:0] pc [2];
  logic [AW-1:0] np [2];
  logic [PRE_W-1:0] pre [2];
  logic [1:0] pre_v, hn, rd;
  tid_t last_tid, gt;
  logic gv, issue;
  // halt requested this cycle already removes the thread from selection
  assign hn = halted | (halt_req ? (2'b01 << halt_tid) : 2'b00);
  assign issue = !stall && gv;
  rr_pick2 u_pick (
    .req(~hn),
    .last(last_tid),
    .gnt_valid(gv),
    .gnt_tid(gt)
  );
  always_comb begin
    rd = '0;
    for (int i = 0; i < 2; i++) begin
      rd[i] = redir_valid && redir_tid == 1'(i) && !hn[i];
      np[i] = !rd[i] ? pc[i] : pre_v[i] ? AW'({pre[i], redir_imm}) : {pc[i][AW-1:IMM_W], redir_imm};
    end
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      pc[0] <= PC_T0;
      pc[1] <= PC_T1;
      pre[0] <= '0;
      pre[1] <= '0;
      pre_v <= '0;
      halted <= '0;
      halt <= 1'b0;
      fetch_valid <= 1'b0;
      fetch_addr <= '0;
      fetch_tid <= 1'b0;
      last_tid <= 1'b1;
    end else begin
      halted <= hn;
      halt <= &halted;
      fetch_valid <= issue;
      for (int i = 0; i < 2; i++) begin
        pc[i] <= (issue && gt == 1'(i)) ? np[i] + AW'(PC_STEP) : np[i];
        if (rd[i]) pre_v[i] <= 1'b0;
        // a same-cycle PRE lands after the redirect consumed the old prefix
        if (pre_load && pre_tid == 1'(i)) begin
          pre[i] <= pre_val;
          pre_v[i] <= 1'b1;
        end
      end
      if (issue) begin
        fetch_addr <= np[gt];
        fetch_tid <= gt;
        last_tid <= gt;
      end
    end
  end
endmodule

// File: tb/tb_thread_sched.sv
// tb_thread_sched: directed checks of issue order, prefix/redirect, stall and halt behaviour.
module tb_thread_sched;
  logic clk = 0, reset = 0, stall, redir_valid, redir_tid, pre_load, pre_tid, halt_req, halt_tid;
  logic [11:0] redir_imm;
  logic [3:0] pre_val;
  logic fetch_valid, fetch_tid, halt;
  logic [15:0] fetch_addr;
  logic [1:0] halted;
  int total = 0, bad = 0;
  always #5 clk = ~clk;
  thread_sched dut (
    .clk(clk), .reset(reset), .stall(stall), .redir_valid(redir_valid), .redir_tid(redir_tid),
    .redir_imm(redir_imm), .pre_load(pre_load), .pre_tid(pre_tid), .pre_val(pre_val),
    .halt_req(halt_req), .halt_tid(halt_tid), .fetch_valid(fetch_valid), .fetch_addr(fetch_addr),
    .fetch_tid(fetch_tid), .halted(halted), .halt(halt)
  );
  task clr;
    stall = 0; redir_valid = 0; redir_tid = 0; redir_imm = 0;
    pre_load = 0; pre_tid = 0; pre_val = 0; halt_req = 0; halt_tid = 0;
  endtask
  task tick;
    @(posedge clk);
    #1;
  endtask
  task do_reset;
    clr;
    reset = 0;
    tick;
    tick;
    reset = 1;
  endtask
  task test_reset;
    do_reset;
    total++;
    if ({halted, halt, fetch_valid, fetch_tid, fetch_addr} !== 21'b0) begin
      bad++;
      $display("FAIL reset_state got h=%b hl=%b v=%b t=%b a=%h want all zero", halted, halt, fetch_valid, fetch_tid, fetch_addr);
    end
    for (int i = 0; i < 4; i++) begin
      tick;
      total++;
      if ({fetch_valid, fetch_tid, fetch_addr, halt} !== {1'b1, i[0], 16'(i), 1'b0}) begin
        bad++;
        $display("FAIL rr_issue[%0d] got v=%b t=%b a=%h hl=%b want v=1 t=%b a=%h hl=0", i, fetch_valid, fetch_tid, fetch_addr, halt, i[0], 16'(i));
      end
    end
  endtask
  task test_halt_one;
    do_reset;
    tick;
    tick;
    halt_req = 1; halt_tid = 1;
    tick;
    clr;
    total++;
    if ({fetch_valid, fetch_tid, fetch_addr, halted} !== {1'b1, 1'b0, 16'h0002, 2'b10}) begin
      bad++;
      $display("FAIL halt1_cycle got v=%b t=%b a=%h h=%b want v=1 t=0 a=0002 h=10", fetch_valid, fetch_tid, fetch_addr, halted);
    end
    for (int i = 0; i < 3; i++) begin
      tick;
      total++;
      if ({fetch_valid, fetch_tid, fetch_addr, halted, halt} !== {1'b1, 1'b0, 16'(4 + 2 * i), 2'b10, 1'b0}) begin
        bad++;
        $display("FAIL halt1_t0only[%0d] got v=%b t=%b a=%h h=%b hl=%b want v=1 t=0 a=%h h=10 hl=0", i, fetch_valid, fetch_tid, fetch_addr, halted, halt, 16'(4 + 2 * i));
      end
    end
  endtask
  task test_prefix;
    logic [16:0] exp [5];
    exp[0] = {1'b1, 16'h0001}; exp[1] = {1'b0, 16'hA123}; exp[2] = {1'b1, 16'h0003};
    exp[3] = {1'b0, 16'hA125}; exp[4] = {1'b1, 16'h0005};
    do_reset;
    pre_load = 1; pre_tid = 0; pre_val = 4'hA;
    tick;
    clr;
    redir_valid = 1; redir_tid = 0; redir_imm = 12'h123;
    for (int i = 0; i < 5; i++) begin
      if (i == 4) begin
        redir_valid = 1; redir_tid = 0; redir_imm = 12'h010;
      end
      tick;
      clr;
      total++;
      if ({fetch_valid, fetch_tid, fetch_addr} !== {1'b1, exp[i]}) begin
        bad++;
        $display("FAIL prefix_seq[%0d] got v=%b t=%b a=%h want v=1 t=%b a=%h", i, fetch_valid, fetch_tid, fetch_addr, exp[i][16], exp[i][15:0]);
      end
    end
    tick;
    total++;
    if ({fetch_tid, fetch_addr} !== {1'b0, 16'hA010}) begin
      bad++;
      $display("FAIL redir_noprefix got t=%b a=%h want t=0 a=A010", fetch_tid, fetch_addr);
    end
  endtask
  task test_pre_redir_same;
    do_reset;
    pre_load = 1; pre_tid = 0; pre_val = 4'h5;
    redir_valid = 1; redir_tid = 0; redir_imm = 12'h100;
    tick;
    clr;
    total++;
    if ({fetch_valid, fetch_tid, fetch_addr} !== {1'b1, 1'b0, 16'h0100}) begin
      bad++;
      $display("FAIL same_cycle_old_prefix got v=%b t=%b a=%h want v=1 t=0 a=0100", fetch_valid, fetch_tid, fetch_addr);
    end
    redir_valid = 1; redir_tid = 0; redir_imm = 12'h020;
    tick;
    clr;
    tick;
    total++;
    if ({fetch_valid, fetch_tid, fetch_addr} !== {1'b1, 1'b0, 16'h5020}) begin
      bad++;
      $display("FAIL same_cycle_new_prefix got v=%b t=%b a=%h want v=1 t=0 a=5020", fetch_valid, fetch_tid, fetch_addr);
    end
  endtask
  task test_stall;
    do_reset;
    tick;
    tick;
    stall = 1; redir_valid = 1; redir_tid = 1; redir_imm = 12'h040;
    for (int i = 0; i < 3; i++) begin
      tick;
      redir_valid = 0;
      total++;
      if ({fetch_valid, fetch_tid, fetch_addr} !== {1'b0, 1'b1, 16'h0001}) begin
        bad++;
        $display("FAIL stall[%0d] got v=%b t=%b a=%h want v=0 t=1 a=0001", i, fetch_valid, fetch_tid, fetch_addr);
      end
    end
    stall = 0;
    for (int i = 0; i < 3; i++) begin
      tick;
      total++;
      if ({fetch_valid, fetch_tid, fetch_addr} !== {1'b1, i[0], (i == 1) ? 16'h0040 : 16'(2 + i)}) begin
        bad++;
        $display("FAIL post_stall[%0d] got v=%b t=%b a=%h want v=1 t=%b a=%h", i, fetch_valid, fetch_tid, fetch_addr, i[0], (i == 1) ? 16'h0040 : 16'(2 + i));
      end
    end
  endtask
  task test_wrap;
    do_reset;
    pre_load = 1; pre_tid = 0; pre_val = 4'hF;
    tick;
    clr;
    redir_valid = 1; redir_tid = 0; redir_imm = 12'hFFE;
    tick;
    clr;
    tick;
    total++;
    if ({fetch_tid, fetch_addr} !== {1'b0, 16'hFFFE}) begin
      bad++;
      $display("FAIL wrap_top got t=%b a=%h want t=0 a=FFFE", fetch_tid, fetch_addr);
    end
    tick;
    tick;
    total++;
    if ({fetch_valid, fetch_tid, fetch_addr} !== {1'b1, 1'b0, 16'h0000}) begin
      bad++;
      $display("FAIL wrap_zero got v=%b t=%b a=%h want v=1 t=0 a=0000", fetch_valid, fetch_tid, fetch_addr);
    end
  endtask
  task test_halt_both;
    do_reset;
    tick;
    halt_req = 1; halt_tid = 0; redir_valid = 1; redir_tid = 0; redir_imm = 12'h300;
    tick;
    clr;
    total++;
    if ({fetch_valid, fetch_tid, fetch_addr, halted, halt} !== {1'b1, 1'b1, 16'h0001, 2'b01, 1'b0}) begin
      bad++;
      $display("FAIL halt0_redir got v=%b t=%b a=%h h=%b hl=%b want v=1 t=1 a=0001 h=01 hl=0", fetch_valid, fetch_tid, fetch_addr, halted, halt);
    end
    halt_req = 1; halt_tid = 1;
    tick;
    clr;
    total++;
    if ({fetch_valid, halted, halt} !== {1'b0, 2'b11, 1'b0}) begin
      bad++;
      $display("FAIL halt_both_set got v=%b h=%b hl=%b want v=0 h=11 hl=0", fetch_valid, halted, halt);
    end
    for (int i = 0; i < 2; i++) begin
      tick;
      total++;
      if ({fetch_valid, halted, halt} !== {1'b0, 2'b11, 1'b1}) begin
        bad++;
        $display("FAIL halt_global[%0d] got v=%b h=%b hl=%b want v=0 h=11 hl=1", i, fetch_valid, halted, halt);
      end
    end
    do_reset;
    total++;
    if ({halted, halt, fetch_valid} !== 4'b0) begin
      bad++;
      $display("FAIL halt_reset got h=%b hl=%b v=%b want 0", halted, halt, fetch_valid);
    end
    for (int i = 0; i < 2; i++) begin
      tick;
      total++;
      if ({fetch_valid, fetch_tid, fetch_addr} !== {1'b1, i[0], 16'(i)}) begin
        bad++;
        $display("FAIL halt_restart[%0d] got v=%b t=%b a=%h want v=1 t=%b a=%h", i, fetch_valid, fetch_tid, fetch_addr, i[0], 16'(i));
      end
    end
  endtask
  initial begin
    clr;
    test_reset;
    test_halt_one;
    test_prefix;
    test_pre_redir_same;
    test_stall;
    test_wrap;
    test_halt_both;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
